hal_filter: RTL and testbench

Hall-sensor input conditioner that sits directly upstream of the commutation (`bldc`) and tachometer (`tacho`) blocks. It synchronises and deglitches the three raw hall inputs and validates the hall sequence. Its outputs are a clean hall code, a one-cycle commutation strobe, a rotation direction, a measured edge-to-edge period, and fault/stall flags for the SPI status word.

---
 rtl/hal_filter.sv | 164 ++++++++++++++++
 tb/tb_hal_filter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hal_filter.sv
// Hall-sensor input conditioner: synchronises and deglitches the raw hall inputs,
// validates the commutation sequence, and reports direction, period, fault and stall.
module hal_filter #(
   parameter int unsigned FILTER_CYCLES = 16,
   parameter int unsigned PERIOD_W      = 24,
   parameter int unsigned STALL_CYCLES  = 2**20
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [2:0]          hal_raw,
   input  logic                fault_clr,
   output logic [2:0]          hal_clean,
   output logic                edge_strobe,
   output logic                dir,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                fault,
   output logic                stalled
);

   localparam int unsigned CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam int unsigned STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
   localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(FILTER_CYCLES - 1);
   localparam logic [STALL_W-1:0]  STALL_MAX = STALL_W'(STALL_CYCLES - 1);
   localparam logic [PERIOD_W-1:0] TIMER_MAX = '1;

   typedef enum logic {UNLOCKED, LOCKED} state_t;

   logic [2:0]          sync1, sync2, cand, last_acc;
   logic [CNT_W-1:0]    cnt;
   logic                accept;

   state_t              state_q, state_d;
   logic [2:0]          clean_d;
   logic                strobe_d, dir_d, pv_d, fault_d, stalled_d, have_d;
   logic [PERIOD_W-1:0] period_d, timer, timer_d;
   logic [STALL_W-1:0]  stall_cnt, stall_cnt_d;
   logic                have_strobe, fault_evt, timer_clr;
   logic                code_valid, fwd, rev;
   logic [2:0]          new_idx, old_idx;

   // Position of a code in the forward sequence 001,011,010,110,100,101.
   function automatic logic [2:0] hall_idx(input logic [2:0] code);
      logic [2:0] idx;
      case (code)
         3'b001:  idx = 3'd0;
         3'b011:  idx = 3'd1;
         3'b010:  idx = 3'd2;
         3'b110:  idx = 3'd3;
         3'b100:  idx = 3'd4;
         3'b101:  idx = 3'd5;
         default: idx = 3'd0;
      endcase
      return idx;
   endfunction

   // Two-flop synchroniser and stability filter; last_acc remembers even invalid codes
   // so a held invalid code raises the fault only once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= 3'b000;
         sync2    <= 3'b000;
         cand     <= 3'b000;
         cnt      <= '0;
         last_acc <= 3'b000;
      end else begin
         sync1 <= hal_raw;
         sync2 <= sync1;
         if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (accept) last_acc <= cand;
      end
   end

   assign accept     = (sync2 == cand) && (cnt == CNT_MAX) && (cand != last_acc);
   assign code_valid = (cand != 3'b000) && (cand != 3'b111);
   assign new_idx    = hall_idx(cand);
   assign old_idx    = hall_idx(hal_clean);
   assign fwd        = (new_idx == ((old_idx == 3'd5) ? 3'd0 : old_idx + 3'd1));
   assign rev        = (new_idx == ((old_idx == 3'd0) ? 3'd5 : old_idx - 3'd1));

   // Lock state machine, period measurement and stall tracking.
   always_comb begin
      state_d   = state_q;
      clean_d   = hal_clean;
      strobe_d  = 1'b0;
      dir_d     = dir;
      period_d  = period;
      pv_d      = period_valid;
      have_d    = have_strobe;
      fault_evt = 1'b0;
      timer_clr = 1'b0;

      if (accept) begin
         if (!code_valid) begin
            fault_evt = 1'b1;
            state_d   = UNLOCKED;
            pv_d      = 1'b0;
            have_d    = 1'b0;
         end else if (state_q == UNLOCKED) begin
            clean_d   = cand;
            state_d   = LOCKED;
            timer_clr = 1'b1;
            have_d    = 1'b0;
         end else if (fwd || rev) begin
            clean_d   = cand;
            strobe_d  = 1'b1;
            dir_d     = fwd;
            timer_clr = 1'b1;
            have_d    = 1'b1;
            if (have_strobe) begin
               period_d = (timer == TIMER_MAX) ? TIMER_MAX : timer + PERIOD_W'(1);
               pv_d     = 1'b1;
            end
         end else begin
            fault_evt = 1'b1;
            clean_d   = cand;
            pv_d      = 1'b0;
            timer_clr = 1'b1;
            have_d    = 1'b0;
         end
      end

      timer_d     = timer_clr ? '0 : ((timer == TIMER_MAX) ? timer : timer + PERIOD_W'(1));
      // Separate stall counter so the stall threshold is independent of PERIOD_W.
      stall_cnt_d = timer_clr ? '0 :
                    ((stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + STALL_W'(1));
      stalled_d   = strobe_d ? 1'b0 : ((stall_cnt_d == STALL_MAX) ? 1'b1 : stalled);
      fault_d     = fault_evt ? 1'b1 : (fault_clr ? 1'b0 : fault);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= UNLOCKED;
         hal_clean    <= 3'b000;
         edge_strobe  <= 1'b0;
         dir          <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         fault        <= 1'b0;
         stalled      <= 1'b1;
         timer        <= '0;
         stall_cnt    <= '0;
         have_strobe  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hal_clean    <= clean_d;
         edge_strobe  <= strobe_d;
         dir          <= dir_d;
         period       <= period_d;
         period_valid <= pv_d;
         fault        <= fault_d;
         stalled      <= stalled_d;
         timer        <= timer_d;
         stall_cnt    <= stall_cnt_d;
         have_strobe  <= have_d;
      end
   end

endmodule

// File: tb/tb_hal_filter.sv
// Self-checking bench for hal_filter: lock, rotation, glitches, faults, stall and reset.
module tb_hal_filter;

   localparam int unsigned FC = 16;
   localparam int unsigned PW = 8;
   localparam int unsigned SC = 1000;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    hal_raw;
   logic          fault_clr;
   logic [2:0]    hal_clean;
   logic          edge_strobe;
   logic          dir;
   logic [PW-1:0] period;
   logic          period_valid;
   logic          fault;
   logic          stalled;

   always #5 clk = ~clk;

   hal_filter #(.FILTER_CYCLES(FC), .PERIOD_W(PW), .STALL_CYCLES(SC)) dut (
      .clk(clk), .reset_n(reset_n), .hal_raw(hal_raw), .fault_clr(fault_clr),
      .hal_clean(hal_clean), .edge_strobe(edge_strobe), .dir(dir), .period(period),
      .period_valid(period_valid), .fault(fault), .stalled(stalled)
   );

   typedef struct {
      logic [2:0] code;
      int         hold;
      int         clr_at;
      logic [2:0] e_clean;
      int         e_strobes;
      logic       e_dir;
      int         e_period;
      logic       e_pv;
      logic       e_fault;
      logic       e_stalled;
   } vec_t;

   vec_t vecs[17];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [2:0] code, input int hold, input int clr_at,
                               input logic [2:0] e_clean, input int e_strobes, input logic e_dir,
                               input int e_period, input logic e_pv, input logic e_fault,
                               input logic e_stalled);
      vec_t v;
      v.code = code; v.hold = hold; v.clr_at = clr_at; v.e_clean = e_clean;
      v.e_strobes = e_strobes; v.e_dir = e_dir; v.e_period = e_period; v.e_pv = e_pv;
      v.e_fault = e_fault; v.e_stalled = e_stalled;
      return v;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_clean"},  int'(hal_clean), 0);
      chk({tag, "_strobe"}, int'(edge_strobe), 0);
      chk({tag, "_dir"},    int'(dir), 0);
      chk({tag, "_period"}, int'(period), 0);
      chk({tag, "_pv"},     int'(period_valid), 0);
      chk({tag, "_fault"},  int'(fault), 0);
      chk({tag, "_stalled"}, int'(stalled), 1);
   endtask

   // Hold hal_raw from just after an edge and check acceptance on edge FC+3 only.
   task automatic lock_window(input string tag, input logic [2:0] code);
      int strobes;
      strobes = 0;
      for (int e = 1; e <= int'(FC) + 3; e++) begin
         tick();
         if (edge_strobe) strobes++;
         if (e == int'(FC) + 2) chk({tag, "_clean_early"}, int'(hal_clean), 0);
      end
      chk({tag, "_clean"},   int'(hal_clean), int'(code));
      chk({tag, "_strobes"}, strobes, 0);
      chk({tag, "_stalled"}, int'(stalled), 1);
      chk({tag, "_fault"},   int'(fault), 0);
   endtask

   task automatic wait_strobe(input string tag, output bit found);
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (edge_strobe) begin
            found = 1'b1;
            break;
         end
      end
      chk({tag, "_strobe_seen"}, int'(found), 1);
   endtask

   initial begin
      int   strobes;
      bit   found;
      vec_t ev;

      //            code    hold clr  clean   n  dir per  pv fault stall
      vecs[0]  = mk(3'b011, 100, -1, 3'b011, 1, 1,   0, 0, 0, 0);
      vecs[1]  = mk(3'b010, 100, -1, 3'b010, 1, 1, 100, 1, 0, 0);
      vecs[2]  = mk(3'b110, 100, -1, 3'b110, 1, 1, 100, 1, 0, 0);
      vecs[3]  = mk(3'b010, 100, -1, 3'b010, 1, 0, 100, 1, 0, 0);
      vecs[4]  = mk(3'b011, 100, -1, 3'b011, 1, 0, 100, 1, 0, 0);
      vecs[5]  = mk(3'b001, 100, -1, 3'b001, 1, 0, 100, 1, 0, 0);
      vecs[6]  = mk(3'b101, 100, -1, 3'b101, 1, 0, 100, 1, 0, 0);
      vecs[7]  = mk(3'b100, 100, -1, 3'b100, 1, 0, 100, 1, 0, 0);
      vecs[8]  = mk(3'b101,  10, -1, 3'b100, 0, 0, 100, 1, 0, 0);
      vecs[9]  = mk(3'b100, 100, -1, 3'b100, 0, 0, 100, 1, 0, 0);
      vecs[10] = mk(3'b101,  16, -1, 3'b100, 0, 0, 100, 1, 0, 0);
      vecs[11] = mk(3'b100, 100, -1, 3'b100, 0, 0, 100, 1, 0, 0);
      vecs[12] = mk(3'b111,  40, -1, 3'b100, 0, 0, 100, 0, 1, 0);
      vecs[13] = mk(3'b010, 100, -1, 3'b010, 0, 0, 100, 0, 1, 0);
      vecs[14] = mk(3'b100, 100, -1, 3'b100, 0, 0, 100, 0, 1, 0);
      vecs[15] = mk(3'b011, 100, 18, 3'b011, 0, 0, 100, 0, 1, 0);
      vecs[16] = mk(3'b011,  30,  5, 3'b011, 0, 0, 100, 0, 0, 0);

      reset_n   = 1'b0;
      hal_raw   = 3'b001;
      fault_clr = 1'b0;
      repeat (3) tick();
      chk_reset_vals("rst");
      reset_n = 1'b1;
      lock_window("lock", 3'b001);
      repeat (20) tick();

      foreach (vecs[i]) begin
         hal_raw = vecs[i].code;
         exp_q.push_back(vecs[i]);
         strobes = 0;
         for (int c = 0; c < vecs[i].hold; c++) begin
            fault_clr = (c == vecs[i].clr_at);
            tick();
            if (edge_strobe) strobes++;
         end
         fault_clr = 1'b0;
         ev = exp_q.pop_front();
         chk($sformatf("v%0d_clean", i),   int'(hal_clean), int'(ev.e_clean));
         chk($sformatf("v%0d_strobes", i), strobes, ev.e_strobes);
         chk($sformatf("v%0d_dir", i),     int'(dir), int'(ev.e_dir));
         chk($sformatf("v%0d_period", i),  int'(period), ev.e_period);
         chk($sformatf("v%0d_pv", i),      int'(period_valid), int'(ev.e_pv));
         chk($sformatf("v%0d_fault", i),   int'(fault), int'(ev.e_fault));
         chk($sformatf("v%0d_stalled", i), int'(stalled), int'(ev.e_stalled));
      end

      // First strobe after a jump: no period update, then idle until stall.
      hal_raw = 3'b010;
      wait_strobe("stall", found);
      chk("stall_dir",    int'(dir), 1);
      chk("stall_pv",     int'(period_valid), 0);
      chk("stall_period", int'(period), 100);
      chk("stall_clear",  int'(stalled), 0);
      tick();
      chk("strobe_width", int'(edge_strobe), 0);
      repeat (int'(SC) - 3) tick();
      chk("stall_998", int'(stalled), 0);
      tick();
      chk("stall_999", int'(stalled), 1);

      // Next strobe after a long idle: saturated period.
      hal_raw = 3'b110;
      wait_strobe("sat", found);
      chk("sat_period",  int'(period), 255);
      chk("sat_pv",      int'(period_valid), 1);
      chk("sat_stalled", int'(stalled), 0);
      chk("sat_dir",     int'(dir), 1);

      // Asynchronous reset in the middle of a filter window.
      hal_raw = 3'b100;
      repeat (10) tick();
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      reset_n = 1'b1;
      lock_window("relock", 3'b100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
